rsa_modexp: RTL and testbench

Square-and-multiply modular exponentiation engine computing c = message^e_key mod n on WIDTH-bit unsigned operands. It sits between the UART receive path and the transmit path: it is started by the one-cycle start pulse derived from the receive-complete edge, takes the received word as message, and its done pulse drives the transmitter write strobe with c as transmit data. It serves both encryption (e) and decryption (d) by choice of e_key.

---
 rtl/rsa_modexp_pkg.sv | 14 +
 rtl/rsa_modexp_mod_mult.sv | 71 +++++++
 rtl/rsa_modexp.sv | 148 ++++++++++++++
 tb/tb_rsa_modexp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_modexp_pkg.sv
// rtl/rsa_modexp_pkg.sv - shared width, FSM encoding and multiply latency for rsa_modexp
package rsa_modexp_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int MULT_LAT  = DEF_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RED  = 2'd1,
        EXP  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/rsa_modexp_mod_mult.sv
// rtl/rsa_modexp_mod_mult.sv - Blakley interleaved modular multiplier, p = a*b mod n, one bit of a per cycle
module rsa_modexp_mod_mult
    import rsa_modexp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] step0;
    logic [WIDTH+1:0] step1;
    logic [WIDTH+1:0] step2;
    logic [CW-1:0]    cnt;
    logic             running;

    // acc < n on entry and b < 2^WIDTH, so 2*acc + b stays below 2n + 2^WIDTH:
    // two conditional subtractions bring it back under n when b < n.
    always_comb begin
        n_ext = {2'b00, n_reg};
        step0 = (acc << 1) + (a_reg[WIDTH-1] ? {2'b00, b_reg} : '0);
        step1 = (step0 >= n_ext) ? step0 - n_ext : step0;
        step2 = (step1 >= n_ext) ? step1 - n_ext : step1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            n_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_reg   <= a;
                b_reg   <= b;
                n_reg   <= n;
                acc     <= '0;
                cnt     <= CW'(WIDTH);
                running <= 1'b1;
            end else if (running) begin
                acc   <= step2;
                a_reg <= a_reg << 1;
                cnt   <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp.sv
// rtl/rsa_modexp.sv - square-and-multiply modular exponentiation, c = message^e_key mod n
module rsa_modexp
    import rsa_modexp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] c,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] base_reg;
    logic [WIDTH-1:0] exp_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] c_reg;
    logic             mult_go;

    logic [WIDTH-1:0] bb_b;
    logic [WIDTH-1:0] bb_p;
    logic [WIDTH-1:0] rb_p;
    logic             bb_done;
    logic             rb_done;
    logic             rb_start;
    logic             iter_done;
    logic             exp_last;
    logic [WIDTH-1:0] unit_val;
    logic [WIDTH-1:0] result_upd;

    // In RED the squaring unit reduces the raw message as message*1.
    assign bb_b       = (state == RED) ? ONE : base_reg;
    assign rb_start   = mult_go && (state == EXP);
    assign iter_done  = bb_done && (rb_done || (state == RED));
    assign exp_last   = (exp_reg >> 1) == '0;
    assign unit_val   = (n_reg == ONE) ? '0 : ONE;
    assign result_upd = exp_reg[0] ? rb_p : result_reg;

    rsa_modexp_mod_mult #(.WIDTH(WIDTH)) u_mult_square (
        .clk   (clk),
        .reset (reset),
        .start (mult_go),
        .a     (base_reg),
        .b     (bb_b),
        .n     (n_reg),
        .p     (bb_p),
        .done  (bb_done)
    );

    rsa_modexp_mod_mult #(.WIDTH(WIDTH)) u_mult_result (
        .clk   (clk),
        .reset (reset),
        .start (rb_start),
        .a     (result_reg),
        .b     (base_reg),
        .n     (n_reg),
        .p     (rb_p),
        .done  (rb_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final multiply pass jumps straight to FIN so done lands one cycle after it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RED;
            end
            RED: begin
                if (n_reg == '0) state_next = FIN;
                else if (iter_done) state_next = (exp_reg == '0) ? FIN : EXP;
            end
            EXP: begin
                if (iter_done && exp_last) state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_reg   <= '0;
            exp_reg    <= '0;
            n_reg      <= '0;
            result_reg <= '0;
            c_reg      <= '0;
            mult_go    <= 1'b0;
        end else begin
            mult_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_reg   <= message;
                        exp_reg    <= e_key;
                        n_reg      <= n;
                        result_reg <= '0;
                        mult_go    <= (n != '0);
                    end
                end
                RED: begin
                    if (n_reg == '0) begin
                        c_reg <= '0;
                    end else if (iter_done) begin
                        base_reg   <= bb_p;
                        result_reg <= unit_val;
                        if (exp_reg == '0) c_reg <= unit_val;
                        else mult_go <= 1'b1;
                    end
                end
                EXP: begin
                    if (iter_done) begin
                        base_reg   <= bb_p;
                        result_reg <= result_upd;
                        exp_reg    <= exp_reg >> 1;
                        if (exp_last) c_reg <= result_upd;
                        else mult_go <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c    = c_reg;
    assign done = (state == FIN);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rsa_modexp.sv
// tb/tb_rsa_modexp.sv - directed and reference-model checks for rsa_modexp
module tb_rsa_modexp;

    localparam int W     = 128;
    localparam int M     = W + 2;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] message = '0;
    logic [W-1:0] e_key = '0;
    logic [W-1:0] n = '0;
    logic [W-1:0] c;
    logic         done;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .message (message),
        .e_key   (e_key),
        .n       (n),
        .c       (c),
        .done    (done),
        .busy    (busy)
    );

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] nn);
        logic [2*W-1:0] r;
        logic [2*W-1:0] b;
        logic [2*W-1:0] nw;
        logic [W-1:0]   ee;
        if (nn == '0) return '0;
        nw = {{W{1'b0}}, nn};
        b  = {{W{1'b0}}, m} % nw;
        r  = (2*W)'(1) % nw;
        ee = e;
        while (ee != '0) begin
            if (ee[0]) r = (r * b) % nw;
            b  = (b * b) % nw;
            ee = ee >> 1;
        end
        return r[W-1:0];
    endfunction

    // Drives one start pulse, scrambles the inputs, waits for done; lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] ek, input logic [W-1:0] nn,
                          output int lat, output logic [W-1:0] res, output bit busy_ok);
        @(negedge clk);
        message = m;
        e_key   = ek;
        n       = nn;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        message = '1;
        e_key   = '1;
        n       = '1;
        lat     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < LIMIT) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        else if (busy !== 1'b1) busy_ok = 1'b0;
        res = c;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (c !== '0)    begin n_bad++; $display("FAIL reset_c: got %0d expected 0", c); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
    endtask

    task automatic test_decrypt();
        int lat; logic [W-1:0] res; bit bok;
        run_op(128'd948, 128'd157, 128'd2773, lat, res, bok);
        n_cmp++; if (lat != 1171)       begin n_bad++; $display("FAIL decrypt_latency: got %0d expected 1171", lat); end
        n_cmp++; if (res !== 128'd920)  begin n_bad++; $display("FAIL decrypt_c: got %0d expected 920", res); end
        n_cmp++; if (bok !== 1'b1)      begin n_bad++; $display("FAIL decrypt_busy: got %b expected 1", bok); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL decrypt_done_pulse: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL decrypt_busy_after: got %b expected 0", busy); end
        n_cmp++; if (c !== 128'd920)    begin n_bad++; $display("FAIL decrypt_c_held: got %0d expected 920", c); end
    endtask

    task automatic test_encrypt();
        int lat; logic [W-1:0] res; bit bok;
        run_op(128'd920, 128'd17, 128'd2773, lat, res, bok);
        n_cmp++; if (lat != 6*M+1)      begin n_bad++; $display("FAIL encrypt_latency: got %0d expected %0d", lat, 6*M+1); end
        n_cmp++; if (res !== 128'd948)  begin n_bad++; $display("FAIL encrypt_c: got %0d expected 948", res); end
    endtask

    task automatic test_edge_exponents();
        int lat; logic [W-1:0] res; bit bok;
        run_op(128'd948, 128'd0, 128'd2773, lat, res, bok);
        n_cmp++; if (lat != M+1)        begin n_bad++; $display("FAIL e0_latency: got %0d expected %0d", lat, M+1); end
        n_cmp++; if (res !== 128'd1)    begin n_bad++; $display("FAIL e0_c: got %0d expected 1", res); end
        run_op(128'd5, 128'd3, 128'd1, lat, res, bok);
        n_cmp++; if (lat != 3*M+1)      begin n_bad++; $display("FAIL n1_latency: got %0d expected %0d", lat, 3*M+1); end
        n_cmp++; if (res !== 128'd0)    begin n_bad++; $display("FAIL n1_c: got %0d expected 0", res); end
        run_op(128'd3000, 128'd1, 128'd2773, lat, res, bok);
        n_cmp++; if (lat != 2*M+1)      begin n_bad++; $display("FAIL e1_latency: got %0d expected %0d", lat, 2*M+1); end
        n_cmp++; if (res !== 128'd227)  begin n_bad++; $display("FAIL e1_c: got %0d expected 227", res); end
        run_op(128'd948, 128'd157, 128'd0, lat, res, bok);
        n_cmp++; if (lat != 2)          begin n_bad++; $display("FAIL n0_latency: got %0d expected 2", lat); end
        n_cmp++; if (res !== 128'd0)    begin n_bad++; $display("FAIL n0_c: got %0d expected 0", res); end
        n_cmp++; if (bok !== 1'b1)      begin n_bad++; $display("FAIL n0_busy: got %b expected 1", bok); end
    endtask

    task automatic test_start_while_busy();
        int dones; int done_lat; logic [W-1:0] res;
        dones = 0; done_lat = -1; res = '0;
        @(negedge clk);
        message = 128'd948; e_key = 128'd157; n = 128'd2773; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 1400; i++) begin
            if (i == 500) begin
                start = 1'b1; message = 128'd1234; e_key = 128'd3; n = 128'd1000;
            end else if (i == 501) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (done_lat < 0) begin done_lat = i; res = c; end
            end
            @(negedge clk);
        end
        n_cmp++; if (dones != 1)        begin n_bad++; $display("FAIL busy_start_dones: got %0d expected 1", dones); end
        n_cmp++; if (done_lat != 1171)  begin n_bad++; $display("FAIL busy_start_latency: got %0d expected 1171", done_lat); end
        n_cmp++; if (res !== 128'd920)  begin n_bad++; $display("FAIL busy_start_c: got %0d expected 920", res); end
        n_cmp++; if (c !== 128'd920)    begin n_bad++; $display("FAIL busy_start_c_held: got %0d expected 920", c); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [W-1:0] res; bit bok;
        @(negedge clk);
        message = 128'd948; e_key = 128'd157; n = 128'd2773; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (599) @(negedge clk);
        n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        n_cmp++; if (c !== '0)          begin n_bad++; $display("FAIL midrst_c: got %0d expected 0", c); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        run_op(128'd948, 128'd157, 128'd2773, lat, res, bok);
        n_cmp++; if (lat != 1171)       begin n_bad++; $display("FAIL midrst_rerun_latency: got %0d expected 1171", lat); end
        n_cmp++; if (res !== 128'd920)  begin n_bad++; $display("FAIL midrst_rerun_c: got %0d expected 920", res); end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] res; bit bok;
        logic [W-1:0] m; logic [W-1:0] ek; logic [W-1:0] nn; logic [W-1:0] mask; logic [W-1:0] exp_c;
        int k; int len;
        for (int t = 0; t < 20; t++) begin
            m  = {$urandom, $urandom, $urandom, $urandom};
            nn = {$urandom, $urandom, $urandom, $urandom};
            if (t % 4 == 1) nn = W'($urandom_range(2, 5000));
            if (nn == '0) nn = W'(1);
            ek = {$urandom, $urandom, $urandom, $urandom};
            if (t == 0) begin
                ek[W-1] = 1'b1;
            end else begin
                len  = $urandom_range(1, 12);
                mask = (W'(1) << len) - W'(1);
                ek   = ek & mask;
            end
            k = 0;
            for (int b = 0; b < W; b++) if (ek[b]) k = b + 1;
            exp_c = ref_modexp(m, ek, nn);
            run_op(m, ek, nn, lat, res, bok);
            n_cmp++; if (res !== exp_c)        begin n_bad++; $display("FAIL random_c[%0d]: got %h expected %h", t, res, exp_c); end
            n_cmp++; if (lat != (k+1)*M+1)     begin n_bad++; $display("FAIL random_latency[%0d]: got %0d expected %0d", t, lat, (k+1)*M+1); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decrypt();
        test_encrypt();
        test_edge_exponents();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
